i2c_start_stop_unit: RTL and testbench
======================================

// Module: i2c_start_stop_unit
// PURPOSE
//  I2C master framing block. Generates START and STOP conditions and a free-running SCL
//  while the controller holds busy. Sits between the master controller FSM and the pad/SDA mux.
//  Outputs iSCL (SCL drive) and oSDA (framing SDA contribution: 0 from START to STOP, 1 when idle).
// PARAMETERS
//  CLK_DIV      2  mclk cycles per SCL half-period ("phase"); legal >=1
//  TBUF_PHASES  2  bus-free phases after STOP (used only with SSU_TBUF_EN); legal >=1
// PORTS
//  mclk  in  1  master clock; only clock, all logic on rising edge
//  rst   in  1  synchronous active-low reset (sampled on mclk rising edge)
//  busy  in  1  1 = transfer requested/in progress; 0 = release bus
//  iSCL  out 1  generated SCL, registered
//  oSDA  out 1  framing SDA, registered
// BEHAVIOUR
//  Reset (rst=0 at edge): state=IDLE, phase counter=0, iSCL=1, oSDA=1.
//  Phase tick: counter counts 0..CLK_DIV-1 in all non-IDLE states; tick = (cnt==CLK_DIV-1).
//    Counter wraps to 0 on tick; held at 0 in IDLE.
//  States (enum):
//    IDLE: iSCL=1, oSDA=1. busy=1 at edge -> START (oSDA drops at that same edge).
//    START: iSCL=1, oSDA=0 for one phase (START hold). On tick -> ACTIVE, iSCL<=0.
//    ACTIVE: oSDA=0. On each tick:
//      if iSCL==1: iSCL<=0 (always complete the high phase);
//      if iSCL==0 and busy==1: iSCL<=1;
//      if iSCL==0 and busy==0: -> STOP, iSCL<=1 (oSDA stays 0).
//    STOP: iSCL=1, oSDA=0 for one phase (STOP setup). On tick: oSDA<=1 and
//      -> IDLE (or BUS_FREE with SSU_TBUF_EN).
//  busy is sampled only at ticks in ACTIVE; a busy pulse shorter than a phase may be missed there.
//  busy changes during START/STOP are ignored; the sequence always completes.
//  busy=1 in IDLE immediately after a STOP starts a new START on the next edge.
//  Reset mid-operation: outputs go to 1/1 at the reset edge, no STOP generated.
//  SCL period in ACTIVE = 2*CLK_DIV mclk cycles, 50% duty.
//  No combinational paths from busy to outputs.
// CONFIGURATION
//  `define SSU_TBUF_EN: adds BUS_FREE state after STOP: iSCL=1, oSDA=1 for TBUF_PHASES phases,
//    busy ignored, then IDLE. Guarantees minimum bus-free time between STOP and next START.
//  Without it: STOP goes directly to IDLE; BUS_FREE state and its counter do not exist.
// STRUCTURE
//  Package ssu_pkg: state enum (IDLE, START, ACTIVE, STOP, BUS_FREE), default CLK_DIV/TBUF_PHASES.
//  Sub-module scl_phase_timer: parameterized phase counter (enable, tick out).
//  The top holds the FSM and output registers.
// TESTING (CLK_DIV=2, mclk period 10 ns)
//  1 rst=0 for 2 edges, busy=0 -> iSCL=1, oSDA=1; counter 0.
//  2 rst=1, busy 0->1 -> oSDA=0 at next edge with iSCL=1; iSCL=0 2 edges later;
//    then iSCL toggles every 2 edges (40 ns period).
//  3 busy=1 for 5 cycles, then 0 -> SCL completes current high phase;
//    at the first low-phase tick iSCL=1 with oSDA=0; 2 edges later oSDA=1; state IDLE.
//  4 busy low 10 cycles, then busy=1 again -> fresh START exactly as scenario 2.
//  5 rst=0 asserted while ACTIVE with iSCL=0 -> iSCL=1, oSDA=1 after that edge; held while rst=0.
//  6 SSU_TBUF_EN, TBUF_PHASES=2, busy=1 during STOP -> after oSDA rises,
//    4 edges with iSCL=1 and oSDA=1 before the START (oSDA=0).

Source files
------------

// File: rtl/i2c_start_stop_unit_pkg.sv
// Shared types and defaults for the I2C START/STOP framing unit.
`default_nettype none

package ssu_pkg;

    localparam int SSU_CLK_DIV     = 2;
    localparam int SSU_TBUF_PHASES = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        ACTIVE   = 3'd2,
        STOP     = 3'd3,
        BUS_FREE = 3'd4
    } ssu_state_e;

endpackage

`default_nettype wire

// File: rtl/i2c_start_stop_unit_scl_phase_timer.sv
// Phase counter for the framing unit: counts 0..CLK_DIV-1 while enabled, ticks on the last count.
`default_nettype none

module scl_phase_timer #(
    parameter int CLK_DIV = 2
) (
    input  logic mclk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge mclk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/i2c_start_stop_unit.sv
// I2C master framing: START/STOP generation and free-running SCL while busy is held.
// Optional macro SSU_TBUF_EN adds a BUS_FREE state of TBUF_PHASES phases after every STOP.
`default_nettype none

module i2c_start_stop_unit
    import ssu_pkg::*;
#(
    parameter int CLK_DIV     = SSU_CLK_DIV,
    parameter int TBUF_PHASES = SSU_TBUF_PHASES
) (
    input  logic mclk,
    input  logic rst,
    input  logic busy,
    output logic iSCL,
    output logic oSDA
);

    if (CLK_DIV < 1 || TBUF_PHASES < 1) begin : g_param_check
        $error("i2c_start_stop_unit: CLK_DIV and TBUF_PHASES must be >= 1");
    end

    ssu_state_e state_q;
    ssu_state_e state_d;
    logic       scl_q;
    logic       scl_d;
    logic       sda_q;
    logic       sda_d;
    logic       tick;
    logic       bf_done;

    scl_phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .mclk_i (mclk),
        .rst_i  (rst),
        .en_i   (state_q != IDLE),
        .tick_o (tick)
    );

`ifdef SSU_TBUF_EN
    localparam int BF_W = (TBUF_PHASES > 1) ? $clog2(TBUF_PHASES) : 1;
    localparam logic [BF_W-1:0] BF_LAST = BF_W'(TBUF_PHASES - 1);

    logic [BF_W-1:0] bf_cnt_q;

    // Counts completed phases spent in BUS_FREE.
    always_ff @(posedge mclk) begin
        if (!rst || state_q != BUS_FREE) begin
            bf_cnt_q <= '0;
        end else if (tick) begin
            bf_cnt_q <= (bf_cnt_q == BF_LAST) ? '0 : bf_cnt_q + BF_W'(1);
        end
    end

    assign bf_done = tick && (bf_cnt_q == BF_LAST);
`else
    assign bf_done = 1'b0;
`endif

    always_ff @(posedge mclk) begin
        if (!rst) begin
            state_q <= IDLE;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (busy) state_d = START;
            START:  if (tick) state_d = ACTIVE;
            ACTIVE: if (tick && !scl_q && !busy) state_d = STOP;
`ifdef SSU_TBUF_EN
            STOP:     if (tick) state_d = BUS_FREE;
            BUS_FREE: if (bf_done) state_d = IDLE;
`else
            STOP:   if (tick) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Next register values for the pads; SCL toggles on every ACTIVE tick, both busy cases raise it.
    always_comb begin
        scl_d = scl_q;
        sda_d = sda_q;
        case (state_q)
            IDLE: begin
                scl_d = 1'b1;
                sda_d = !busy;
            end
            START: begin
                scl_d = !tick;
                sda_d = 1'b0;
            end
            ACTIVE: begin
                sda_d = 1'b0;
                if (tick) scl_d = !scl_q;
            end
            STOP: begin
                scl_d = 1'b1;
                sda_d = tick;
            end
            default: begin
                scl_d = 1'b1;
                sda_d = 1'b1;
            end
        endcase
    end

    assign iSCL = scl_q;
    assign oSDA = sda_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_start_stop_unit.sv
// Directed self-checking bench for i2c_start_stop_unit with CLK_DIV=2, TBUF_PHASES=2.
`default_nettype none

module tb_i2c_start_stop_unit;

    logic mclk = 1'b0;
    logic rst  = 1'b0;
    logic busy = 1'b0;
    logic iSCL;
    logic oSDA;

    int n_cmp = 0;
    int n_bad = 0;

    i2c_start_stop_unit #(
        .CLK_DIV     (2),
        .TBUF_PHASES (2)
    ) dut (
        .mclk (mclk),
        .rst  (rst),
        .busy (busy),
        .iSCL (iSCL),
        .oSDA (oSDA)
    );

    always #5 mclk = ~mclk;

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        busy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (iSCL !== 1'b1 || oSDA !== 1'b1) begin
                n_bad++;
                $display("FAIL reset edge%0d: scl=%b sda=%b required scl=1 sda=1", i, iSCL, oSDA);
            end
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if (iSCL !== 1'b1 || oSDA !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_after_reset: scl=%b sda=%b required scl=1 sda=1", iSCL, oSDA);
        end
    endtask

    // Starts from IDLE; leaves the unit in ACTIVE after n_active ACTIVE edges.
    task automatic test_start(input int n_active);
        logic exp_scl;
        busy = 1'b1;
        step();
        n_cmp++;
        if (iSCL !== 1'b1 || oSDA !== 1'b0) begin
            n_bad++;
            $display("FAIL start_edge0: scl=%b sda=%b required scl=1 sda=0", iSCL, oSDA);
        end
        step();
        n_cmp++;
        if (iSCL !== 1'b1 || oSDA !== 1'b0) begin
            n_bad++;
            $display("FAIL start_hold: scl=%b sda=%b required scl=1 sda=0", iSCL, oSDA);
        end
        for (int k = 0; k < n_active; k++) begin
            step();
            exp_scl = ((k / 2) % 2) != 0;
            n_cmp++;
            if (iSCL !== exp_scl || oSDA !== 1'b0) begin
                n_bad++;
                $display("FAIL active_k%0d: scl=%b sda=%b required scl=%b sda=0", k, iSCL, oSDA, exp_scl);
            end
        end
    endtask

    // Entered one edge into the SCL high phase: the high phase must complete before STOP.
    task automatic test_stop_high();
        logic [1:0] exp [6] = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b11, 2'b11};
        busy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if ({iSCL, oSDA} !== exp[i]) begin
                n_bad++;
                $display("FAIL stop_high_%0d: scl,sda=%b required %b", i, {iSCL, oSDA}, exp[i]);
            end
        end
    endtask

    // Entered one edge into a low phase: STOP begins at the very next tick.
    task automatic test_stop_low();
        logic [1:0] exp [4] = '{2'b10, 2'b10, 2'b11, 2'b11};
        busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if ({iSCL, oSDA} !== exp[i]) begin
                n_bad++;
                $display("FAIL stop_low_%0d: scl,sda=%b required %b", i, {iSCL, oSDA}, exp[i]);
            end
        end
    endtask

    task automatic test_idle_gap(input int n);
        int bad = 0;
        busy = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            if (iSCL !== 1'b1 || oSDA !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL idle_gap: %0d edges not idle, required 0", bad);
        end
    endtask

    // busy re-asserted during STOP is ignored; the next START follows the STOP (and any bus-free time).
`ifdef SSU_TBUF_EN
    localparam int B2B_LEN = 11;
    localparam logic [1:0] B2B_EXP [B2B_LEN] = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b11,
                                                 2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10};
`else
    localparam int B2B_LEN = 7;
    localparam logic [1:0] B2B_EXP [B2B_LEN] = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b11,
                                                 2'b10, 2'b10};
`endif

    task automatic test_back_to_back();
        logic [1:0] exp [B2B_LEN] = B2B_EXP;
        test_start(8);
        busy = 1'b0;
        for (int i = 0; i < B2B_LEN; i++) begin
            step();
            if (i == 2) busy = 1'b1;
            n_cmp++;
            if ({iSCL, oSDA} !== exp[i]) begin
                n_bad++;
                $display("FAIL b2b_%0d: scl,sda=%b required %b", i, {iSCL, oSDA}, exp[i]);
            end
        end
        step();
        n_cmp++;
        if (iSCL !== 1'b0 || oSDA !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_active: scl=%b sda=%b required scl=0 sda=0", iSCL, oSDA);
        end
    endtask

    // Called with the unit in ACTIVE and SCL low.
    task automatic test_reset_mid();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (iSCL !== 1'b1 || oSDA !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_mid_%0d: scl=%b sda=%b required scl=1 sda=1", i, iSCL, oSDA);
            end
        end
        busy = 1'b0;
        rst  = 1'b1;
        step();
        step();
        n_cmp++;
        if (iSCL !== 1'b1 || oSDA !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_release: scl=%b sda=%b required scl=1 sda=1", iSCL, oSDA);
        end
    endtask

    initial begin
        test_reset();
        test_start(8);
        test_stop_high();
        test_idle_gap(10);
        test_start(8);
        test_stop_high();
        test_idle_gap(10);
        test_start(2);
        test_stop_low();
        test_idle_gap(10);
        test_back_to_back();
        test_reset_mid();
        test_idle_gap(4);
        test_start(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
